// File: rtl/types_pkg.sv
// ---------------------------------------------------------------------------
// types_pkg
// Shared types and default sizing for the register-read stage.
//   rs_data_t   : entry issued by the reservation station (valid flag,
//                 source/destination physical registers, opcode)
//   DEF_*       : default widths/counts used as parameter defaults
// ---------------------------------------------------------------------------
package types_pkg;

   localparam int DEF_NUM_CH = 3;   // issue channels: 0=ALU, 1=branch, 2=LSU
   localparam int DEF_NUM_WB = 3;   // writeback / bypass ports
   localparam int DEF_PREG_W = 7;   // physical register index width
   localparam int DEF_DATA_W = 32;  // operand width
   localparam int DEF_CNT_W  = 16;  // stall counter width

   localparam int NUM_SRC = 2;      // source operands per op

   typedef struct packed {
      logic                  valid;
      logic [DEF_PREG_W-1:0] pr1;
      logic [DEF_PREG_W-1:0] pr2;
      logic [DEF_PREG_W-1:0] pd;
      logic [3:0]            opcode;
   } rs_data_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// ---------------------------------------------------------------------------
// reg_read_stage_if
// Bundles every non-clock signal of the register-read stage.
//   slave  : view of the stage itself (consumes issue/PRF/wb/FU-ready,
//            produces ready, PRF read requests and the FU bundle)
//   master : view of the surrounding pipeline (RS, PRF, writeback, FU)
// ---------------------------------------------------------------------------
interface reg_read_stage_if #(
   parameter int NUM_CH = types_pkg::DEF_NUM_CH,
   parameter int NUM_WB = types_pkg::DEF_NUM_WB,
   parameter int PREG_W = types_pkg::DEF_PREG_W,
   parameter int DATA_W = types_pkg::DEF_DATA_W,
   parameter int CNT_W  = types_pkg::DEF_CNT_W
);
   import types_pkg::*;

   // issue side
   logic [NUM_CH-1:0]                         issue_valid;
   rs_data_t [NUM_CH-1:0]                     issue_data;
   logic [NUM_CH-1:0]                         issue_ready;
   // physical register file read ports
   logic [NUM_CH-1:0][NUM_SRC-1:0]            rd_en;
   logic [NUM_CH-1:0][NUM_SRC-1:0][PREG_W-1:0] rd_addr;
   logic [NUM_CH-1:0][NUM_SRC-1:0][DATA_W-1:0] rd_data;
   // writeback bypass
   logic [NUM_WB-1:0]                         wb_valid;
   logic [NUM_WB-1:0][PREG_W-1:0]             wb_preg;
   logic [NUM_WB-1:0][DATA_W-1:0]             wb_data;
   logic                                      flush;
   // functional-unit side
   logic [NUM_CH-1:0]                         fu_valid;
   logic [NUM_CH-1:0]                         fu_ready;
   rs_data_t [NUM_CH-1:0]                     fu_op;
   logic [NUM_CH-1:0][DATA_W-1:0]             fu_src1;
   logic [NUM_CH-1:0][DATA_W-1:0]             fu_src2;
   logic [NUM_CH-1:0][CNT_W-1:0]              stall_cnt;

   modport slave (
      input  issue_valid, issue_data, rd_data, wb_valid, wb_preg, wb_data,
             flush, fu_ready,
      output issue_ready, rd_en, rd_addr, fu_valid, fu_op, fu_src1, fu_src2,
             stall_cnt
   );

   modport master (
      output issue_valid, issue_data, rd_data, wb_valid, wb_preg, wb_data,
             flush, fu_ready,
      input  issue_ready, rd_en, rd_addr, fu_valid, fu_op, fu_src1, fu_src2,
             stall_cnt
   );

endinterface

// File: rtl/operand_bypass.sv
// ---------------------------------------------------------------------------
// operand_bypass
// Combinational operand selection for one source of one channel.
//   preg_i     : physical register being read
//   prf_data_i : value returned by the register file this cycle
//   wb_*_i     : writeback ports that may carry a fresher value
//   operand_o  : preg 0 reads as zero; otherwise the lowest-numbered
//                matching writeback port wins, else the PRF value
// ---------------------------------------------------------------------------
module operand_bypass #(
   parameter int NUM_WB = types_pkg::DEF_NUM_WB,
   parameter int PREG_W = types_pkg::DEF_PREG_W,
   parameter int DATA_W = types_pkg::DEF_DATA_W
) (
   input  logic [PREG_W-1:0]             preg_i,
   input  logic [DATA_W-1:0]             prf_data_i,
   input  logic [NUM_WB-1:0]             wb_valid_i,
   input  logic [NUM_WB-1:0][PREG_W-1:0] wb_preg_i,
   input  logic [NUM_WB-1:0][DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0]             operand_o
);
   import types_pkg::*;

   logic [DATA_W-1:0] sel_s;

   // Priority mux: walking from the highest port down lets port 0 win last.
   always_comb begin
      sel_s = prf_data_i;
      for (int i = NUM_WB - 1; i >= 0; i--) begin
         sel_s = (wb_valid_i[i] && (wb_preg_i[i] == preg_i)) ? wb_data_i[i] : sel_s;
      end
      operand_o = (preg_i == '0) ? '0 : sel_s;
   end

endmodule

// File: rtl/reg_read_stage.sv
// ---------------------------------------------------------------------------
// reg_read_stage
// One-entry pipeline register per issue channel between the reservation
// stations and the functional units. Reads operands from the PRF (with
// writeback bypass) in the issue cycle and presents {op, src1, src2} to the
// FU one cycle later.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : reg_read_stage_if.slave (issue, PRF read, writeback, flush,
//           FU handshake and per-channel stall counters)
// ---------------------------------------------------------------------------
module reg_read_stage #(
   parameter int NUM_CH = types_pkg::DEF_NUM_CH,
   parameter int NUM_WB = types_pkg::DEF_NUM_WB,
   parameter int PREG_W = types_pkg::DEF_PREG_W,
   parameter int DATA_W = types_pkg::DEF_DATA_W,
   parameter int CNT_W  = types_pkg::DEF_CNT_W
) (
   input  logic           clk,
   input  logic           reset,
   reg_read_stage_if.slave bus
);
   import types_pkg::*;

   logic [NUM_CH-1:0]                          valid_q, valid_d;
   rs_data_t [NUM_CH-1:0]                      op_q, op_d;
   logic [NUM_CH-1:0][DATA_W-1:0]              src1_q, src1_d;
   logic [NUM_CH-1:0][DATA_W-1:0]              src2_q, src2_d;
   logic [NUM_CH-1:0][CNT_W-1:0]               cnt_q, cnt_d;

   logic [NUM_CH-1:0]                          req_s;
   logic [NUM_CH-1:0]                          ready_s;
   logic [NUM_CH-1:0]                          accept_s;
   logic [NUM_CH-1:0][NUM_SRC-1:0]             en_s;
   logic [NUM_CH-1:0][NUM_SRC-1:0][PREG_W-1:0] addr_s;
   logic [DATA_W-1:0]                          opnd_s [NUM_CH][NUM_SRC];

   // Handshake and PRF read requests; ready is held low while in reset.
   always_comb begin
      req_s    = '0;
      ready_s  = '0;
      accept_s = '0;
      en_s     = '0;
      addr_s   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         req_s[c]     = bus.issue_valid[c] && bus.issue_data[c].valid;
         ready_s[c]   = !reset && !bus.flush && (!valid_q[c] || bus.fu_ready[c]);
         accept_s[c]  = req_s[c] && ready_s[c];
         en_s[c]      = {NUM_SRC{req_s[c]}};
         addr_s[c][0] = req_s[c] ? bus.issue_data[c].pr1 : '0;
         addr_s[c][1] = req_s[c] ? bus.issue_data[c].pr2 : '0;
      end
   end

   genvar gc, gs;
   generate
      for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
         for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
            operand_bypass #(
               .NUM_WB (NUM_WB),
               .PREG_W (PREG_W),
               .DATA_W (DATA_W)
            ) u_bypass (
               .preg_i     (addr_s[gc][gs]),
               .prf_data_i (bus.rd_data[gc][gs]),
               .wb_valid_i (bus.wb_valid),
               .wb_preg_i  (bus.wb_preg),
               .wb_data_i  (bus.wb_data),
               .operand_o  (opnd_s[gc][gs])
            );
         end
      end
   endgenerate

   // Next state: flush kills the entry; accept replaces it (no bubble even
   // when the FU drains it the same cycle); otherwise hold or drain.
   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      cnt_d   = cnt_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.flush) begin
            valid_d[c] = 1'b0;
         end else if (accept_s[c]) begin
            valid_d[c] = 1'b1;
            op_d[c]    = bus.issue_data[c];
            src1_d[c]  = opnd_s[c][0];
            src2_d[c]  = opnd_s[c][1];
         end else if (bus.fu_ready[c]) begin
            valid_d[c] = 1'b0;
         end else begin
            valid_d[c] = valid_q[c];
         end

         // Stall counter saturates instead of wrapping.
         if (valid_q[c] && !bus.fu_ready[c] && !bus.flush &&
             (cnt_q[c] != {CNT_W{1'b1}})) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end else begin
            cnt_d[c] = cnt_q[c];
         end
      end
   end

   // Pipeline and stall-counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         op_q    <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.issue_ready = ready_s;
   assign bus.rd_en       = en_s;
   assign bus.rd_addr     = addr_s;
   assign bus.fu_valid    = valid_q;
   assign bus.fu_op       = op_q;
   assign bus.fu_src1     = src1_q;
   assign bus.fu_src2     = src2_q;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// ---------------------------------------------------------------------------
// tb_reg_read_stage
// Directed bench for reg_read_stage. A second instance with a 4-bit stall
// counter sees identical stimulus so counter saturation is reachable in a
// short run.
// ---------------------------------------------------------------------------
module tb_reg_read_stage;
   import types_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   reg_read_stage_if #(.NUM_CH(3), .NUM_WB(3), .PREG_W(7), .DATA_W(32), .CNT_W(16)) ifm ();
   reg_read_stage_if #(.NUM_CH(3), .NUM_WB(3), .PREG_W(7), .DATA_W(32), .CNT_W(4))  ifs ();

   reg_read_stage #(.NUM_CH(3), .NUM_WB(3), .PREG_W(7), .DATA_W(32), .CNT_W(16)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (ifm.slave)
   );

   reg_read_stage #(.NUM_CH(3), .NUM_WB(3), .PREG_W(7), .DATA_W(32), .CNT_W(4)) u_sat (
      .clk   (clk),
      .reset (rst),
      .bus   (ifs.slave)
   );

   assign ifs.issue_valid = ifm.issue_valid;
   assign ifs.issue_data  = ifm.issue_data;
   assign ifs.rd_data     = ifm.rd_data;
   assign ifs.wb_valid    = ifm.wb_valid;
   assign ifs.wb_preg     = ifm.wb_preg;
   assign ifs.wb_data     = ifm.wb_data;
   assign ifs.flush       = ifm.flush;
   assign ifs.fu_ready    = ifm.fu_ready;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file contents seen by the stage.
   function automatic logic [31:0] prf_val(input logic [6:0] a);
      if (a == 7'd0)      return 32'hFFFF_FFFF;
      else if (a == 7'd5) return 32'h0000_0011;
      else if (a == 7'd6) return 32'h0000_0022;
      else                return 32'hA000_0000 | {25'd0, a};
   endfunction

   // Combinational PRF model.
   always_comb begin
      ifm.rd_data = '0;
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < 2; s++) begin
            ifm.rd_data[c][s] = prf_val(ifm.rd_addr[c][s]);
         end
      end
   end

   typedef struct {
      logic        vld;
      logic [6:0]  pr1, pr2;
      logic [3:0]  opc;
      logic [2:0]  wbv;
      logic [6:0]  wp0, wp1, wp2;
      logic [31:0] wd0, wd1, wd2;
      logic [31:0] e1, e2;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input logic vld, input logic [6:0] p1, input logic [6:0] p2,
                               input logic [3:0] opc, input logic [2:0] wbv,
                               input logic [6:0] w0, input logic [6:0] w1, input logic [6:0] w2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] e1, input logic [31:0] e2);
      vec_t v;
      v.vld = vld; v.pr1 = p1; v.pr2 = p2; v.opc = opc; v.wbv = wbv;
      v.wp0 = w0; v.wp1 = w1; v.wp2 = w2; v.wd0 = d0; v.wd1 = d1; v.wd2 = d2;
      v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_issue(input int c, input logic v, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [3:0] opc);
      rs_data_t e;
      e.valid  = v;
      e.pr1    = p1;
      e.pr2    = p2;
      e.pd     = 7'd10;
      e.opcode = opc;
      ifm.issue_data[c]  = e;
      ifm.issue_valid[c] = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = mk(1'b1, 7'd5, 7'd6, 4'h1, 3'b000, 7'd0, 7'd0, 7'd0, 32'h0, 32'h0, 32'h0,
                   32'h11, 32'h22);
      vecs[1] = mk(1'b1, 7'd5, 7'd6, 4'h2, 3'b110, 7'd0, 7'd5, 7'd5, 32'h0, 32'hAB, 32'hCD,
                   32'hAB, 32'h22);
      vecs[2] = mk(1'b1, 7'd0, 7'd6, 4'h3, 3'b000, 7'd0, 7'd0, 7'd0, 32'h0, 32'h0, 32'h0,
                   32'h0, 32'h22);
      vecs[3] = mk(1'b1, 7'd7, 7'd6, 4'h4, 3'b011, 7'd6, 7'd6, 7'd0, 32'h600D, 32'hBAD, 32'h0,
                   32'hA000_0007, 32'h600D);
      vecs[4] = mk(1'b1, 7'd5, 7'd8, 4'h5, 3'b000, 7'd5, 7'd0, 7'd0, 32'hDEAD, 32'h0, 32'h0,
                   32'h11, 32'hA000_0008);
      vecs[5] = mk(1'b0, 7'd5, 7'd6, 4'h6, 3'b000, 7'd0, 7'd0, 7'd0, 32'h0, 32'h0, 32'h0,
                   32'h0, 32'h0);
      vecs[6] = mk(1'b1, 7'd0, 7'd9, 4'h7, 3'b001, 7'd0, 7'd0, 7'd0, 32'h1234, 32'h0, 32'h0,
                   32'h0, 32'hA000_0009);
      vecs[7] = mk(1'b1, 7'd8, 7'd9, 4'h8, 3'b100, 7'd0, 7'd0, 7'd9, 32'h0, 32'h0, 32'h99,
                   32'hA000_0008, 32'h99);
      vecs[8] = mk(1'b1, 7'd9, 7'd9, 4'h9, 3'b111, 7'd3, 7'd9, 7'd9, 32'h1, 32'h77, 32'h88,
                   32'h77, 32'h77);

      // Reset with an op already presented on the ALU channel.
      rst = 1'b1;
      ifm.issue_valid = '0;
      ifm.issue_data  = '0;
      ifm.wb_valid    = '0;
      ifm.wb_preg     = '0;
      ifm.wb_data     = '0;
      ifm.flush       = 1'b0;
      ifm.fu_ready    = 3'b111;
      set_issue(0, 1'b1, 7'd5, 7'd6, 4'h3);
      #2;
      check("reset_ready", 64'(ifm.issue_ready), 64'd0);
      check("reset_fu_valid", 64'(ifm.fu_valid), 64'd0);
      check("reset_src1", 64'(ifm.fu_src1[0]), 64'd0);
      check("reset_stall", 64'(ifm.stall_cnt[2]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 64'(ifm.issue_ready), 64'h7);
      @(posedge clk); #1;
      check("first_accept_valid", 64'(ifm.fu_valid), 64'h1);
      check("first_accept_src1", 64'(ifm.fu_src1[0]), 64'h11);
      check("first_accept_src2", 64'(ifm.fu_src2[0]), 64'h22);

      // Table-driven operand selection on channel 0, one op per cycle.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         ifm.issue_valid = '0;
         set_issue(0, vecs[i].vld, vecs[i].pr1, vecs[i].pr2, vecs[i].opc);
         ifm.wb_valid   = vecs[i].wbv;
         ifm.wb_preg[0] = vecs[i].wp0;
         ifm.wb_preg[1] = vecs[i].wp1;
         ifm.wb_preg[2] = vecs[i].wp2;
         ifm.wb_data[0] = vecs[i].wd0;
         ifm.wb_data[1] = vecs[i].wd1;
         ifm.wb_data[2] = vecs[i].wd2;
         #1;
         check("vec_ready", 64'(ifm.issue_ready[0]), 64'd1);
         check("vec_rd_en", 64'(ifm.rd_en[0]), vecs[i].vld ? 64'd3 : 64'd0);
         check("vec_rd_addr1", 64'(ifm.rd_addr[0][0]), vecs[i].vld ? 64'(vecs[i].pr1) : 64'd0);
         check("vec_rd_addr2", 64'(ifm.rd_addr[0][1]), vecs[i].vld ? 64'(vecs[i].pr2) : 64'd0);
         @(posedge clk); #1;
         check("vec_fu_valid", 64'(ifm.fu_valid[0]), 64'(vecs[i].vld));
         if (vecs[i].vld) begin
            check("vec_src1", 64'(ifm.fu_src1[0]), 64'(vecs[i].e1));
            check("vec_src2", 64'(ifm.fu_src2[0]), 64'(vecs[i].e2));
            check("vec_opcode", 64'(ifm.fu_op[0].opcode), 64'(vecs[i].opc));
         end
      end

      // LSU stall for four cycles while ALU and branch keep flowing.
      @(negedge clk);
      ifm.wb_valid = '0;
      set_issue(0, 1'b1, 7'd20, 7'd21, 4'h1);
      set_issue(1, 1'b1, 7'd22, 7'd23, 4'h2);
      set_issue(2, 1'b1, 7'd5, 7'd6, 4'hC);
      ifm.fu_ready = 3'b111;
      @(posedge clk); #1;
      check("stall_load_valid", 64'(ifm.fu_valid), 64'h7);
      check("stall_load_src1", 64'(ifm.fu_src1[2]), 64'h11);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ifm.fu_ready = 3'b011;
         set_issue(0, 1'b1, 7'(30 + k), 7'd21, 4'h1);
         set_issue(2, 1'b1, 7'(40 + k), 7'd41, 4'hD);
         #1;
         check("stall_ready", 64'(ifm.issue_ready), 64'h3);
         @(posedge clk); #1;
         check("stall_valid", 64'(ifm.fu_valid), 64'h7);
         check("stall_hold_src1", 64'(ifm.fu_src1[2]), 64'h11);
         check("stall_hold_src2", 64'(ifm.fu_src2[2]), 64'h22);
         check("stall_hold_op", 64'(ifm.fu_op[2].opcode), 64'hC);
         check("stall_alu_flow", 64'(ifm.fu_src1[0]), 64'(32'hA000_0000 + 32'(30 + k)));
      end
      check("stall_cnt2", 64'(ifm.stall_cnt[2]), 64'd4);
      check("stall_cnt0", 64'(ifm.stall_cnt[0]), 64'd0);
      check("stall_cnt1", 64'(ifm.stall_cnt[1]), 64'd0);
      @(negedge clk);
      ifm.issue_valid = '0;
      ifm.fu_ready    = 3'b111;
      @(posedge clk); #1;
      check("drain_valid", 64'(ifm.fu_valid), 64'd0);
      check("drain_cnt2", 64'(ifm.stall_cnt[2]), 64'd4);

      // Flush with every channel holding an op and issuing a new one.
      @(negedge clk);
      set_issue(0, 1'b1, 7'd5, 7'd6, 4'h1);
      set_issue(1, 1'b1, 7'd5, 7'd6, 4'h2);
      set_issue(2, 1'b1, 7'd5, 7'd6, 4'h3);
      @(posedge clk); #1;
      check("flush_pre_valid", 64'(ifm.fu_valid), 64'h7);
      @(negedge clk);
      ifm.flush    = 1'b1;
      ifm.fu_ready = 3'b000;
      set_issue(0, 1'b1, 7'd7, 7'd8, 4'h4);
      set_issue(1, 1'b1, 7'd7, 7'd8, 4'h5);
      set_issue(2, 1'b1, 7'd7, 7'd8, 4'h6);
      #1;
      check("flush_ready", 64'(ifm.issue_ready), 64'd0);
      @(posedge clk); #1;
      check("flush_valid", 64'(ifm.fu_valid), 64'd0);
      check("flush_no_stall0", 64'(ifm.stall_cnt[0]), 64'd0);
      check("flush_no_stall2", 64'(ifm.stall_cnt[2]), 64'd4);
      @(negedge clk);
      ifm.flush       = 1'b0;
      ifm.issue_valid = '0;
      ifm.fu_ready    = 3'b111;
      @(posedge clk); #1;
      check("post_flush_valid", 64'(ifm.fu_valid), 64'd0);

      // Long LSU stall: 4-bit counter saturates, 16-bit one keeps counting.
      @(negedge clk);
      set_issue(2, 1'b1, 7'd5, 7'd6, 4'hE);
      @(posedge clk); #1;
      @(negedge clk);
      ifm.issue_valid = '0;
      ifm.fu_ready    = 3'b011;
      repeat (20) @(posedge clk);
      #1;
      check("long_stall_cnt16", 64'(ifm.stall_cnt[2]), 64'd24);
      check("sat_stall_cnt4", 64'(ifs.stall_cnt[2]), 64'hF);
      check("long_stall_hold", 64'(ifm.fu_src1[2]), 64'h11);

      // Asynchronous reset in the middle of the stall, away from any edge.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(ifm.fu_valid), 64'd0);
      check("async_rst_op", 64'(ifm.fu_op[2]), 64'd0);
      check("async_rst_src1", 64'(ifm.fu_src1[2]), 64'd0);
      check("async_rst_src2", 64'(ifm.fu_src2[2]), 64'd0);
      check("async_rst_cnt16", 64'(ifm.stall_cnt[2]), 64'd0);
      check("async_rst_cnt4", 64'(ifs.stall_cnt[2]), 64'd0);
      check("async_rst_ready", 64'(ifm.issue_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
